// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RV32 5-stage hazard sequencer (load-use, redirect, memory wait) with cycle/instret counters.
// Optional HAZ_PERF_CNT_EN adds stall/flush event counters.  Rev 1.0
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_exe_memread,
  input  logic [4:0]       i_exe_rd,
  input  logic             i_exe_redirect,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  input  logic             i_wb_retire,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush,
  output logic             o_idexe_flush,
  output logic             o_pipe_freeze,
  output logic             o_redirect_go,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instret_cnt,
`ifdef HAZ_PERF_CNT_EN
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
`endif
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    REPLAY   = 2'd3
  } state_t;

  localparam logic [1:0]       c_LU_INIT = 2'(LU_BUBBLES - 1);
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_lu_cnt, w_lu_cnt_nxt;
  logic             r_pend_redir, w_pend_redir_nxt;
  logic [CNT_W-1:0] r_cycle_cnt, r_instret_cnt;

  logic w_lu_hit, w_mem_wait;
  logic w_freeze, w_stall, w_redir;

  assign w_lu_hit   = i_exe_memread && (i_exe_rd != 5'd0) &&
                      ((i_id_use_rs1 && (i_id_rs1 == i_exe_rd)) ||
                       (i_id_use_rs2 && (i_id_rs2 == i_exe_rd)));
  assign w_mem_wait = i_mem_req && !i_mem_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_lu_cnt_nxt     = r_lu_cnt;
    w_pend_redir_nxt = r_pend_redir;
    w_freeze         = 1'b0;
    w_stall          = 1'b0;
    w_redir          = 1'b0;
    case (r_state)
      RUN, LU_STALL: begin
        if (w_mem_wait) begin
          w_freeze         = 1'b1;
          w_pend_redir_nxt = i_exe_redirect;
          w_state_nxt      = MEM_WAIT;
        end else if (i_exe_redirect) begin
          w_redir      = 1'b1;
          w_lu_cnt_nxt = 2'd0;
          w_state_nxt  = RUN;
        end else if (r_state == LU_STALL) begin
          w_stall      = 1'b1;
          w_lu_cnt_nxt = r_lu_cnt - 2'd1;
          w_state_nxt  = (r_lu_cnt == 2'd1) ? RUN : LU_STALL;
        end else if (w_lu_hit) begin
          w_stall      = 1'b1;
          w_lu_cnt_nxt = c_LU_INIT;
          w_state_nxt  = (c_LU_INIT != 2'd0) ? LU_STALL : RUN;
        end
      end
      MEM_WAIT: begin
        // A suspended load-use sequence resumes once the wait clears
        if (w_mem_wait) begin
          w_freeze         = 1'b1;
          w_pend_redir_nxt = r_pend_redir | i_exe_redirect;
        end else if (r_pend_redir) begin
          w_state_nxt = REPLAY;
        end else if (r_lu_cnt != 2'd0) begin
          w_state_nxt = LU_STALL;
        end else begin
          w_state_nxt = RUN;
        end
      end
      REPLAY: begin
        w_redir          = 1'b1;
        w_pend_redir_nxt = 1'b0;
        w_lu_cnt_nxt     = 2'd0;
        w_state_nxt      = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= RUN;
      r_lu_cnt      <= 2'd0;
      r_pend_redir  <= 1'b0;
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_lu_cnt     <= w_lu_cnt_nxt;
      r_pend_redir <= w_pend_redir_nxt;
      r_cycle_cnt  <= r_cycle_cnt + c_ONE;
      if (i_wb_retire && !w_freeze) begin
        r_instret_cnt <= r_instret_cnt + c_ONE;
      end
    end
  end

  assign o_pc_stall    = !reset && (w_freeze || w_stall);
  assign o_ifid_stall  = !reset && (w_freeze || w_stall);
  assign o_ifid_flush  = !reset && w_redir;
  assign o_idexe_flush = !reset && (w_redir || w_stall);
  assign o_pipe_freeze = !reset && w_freeze;
  assign o_redirect_go = !reset && w_redir;
  assign o_cycle_cnt   = r_cycle_cnt;
  assign o_instret_cnt = r_instret_cnt;
  assign o_state       = r_state;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_freeze || w_stall) r_stall_cnt <= r_stall_cnt + c_ONE;
      if (w_redir)             r_flush_cnt <= r_flush_cnt + c_ONE;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed + random stimulus against a bubble/freeze/replay reference model.
// Two DUTs share inputs: defaults, and LU_BUBBLES=3 with a 4-bit counter for wrap coverage.
`default_nettype none

module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, exe_rd;
  logic       id_use_rs1, id_use_rs2, exe_memread, exe_redirect;
  logic       mem_req, mem_ready, wb_retire;

  // control bit order: {pc_stall, ifid_stall, ifid_flush, idexe_flush, pipe_freeze, redirect_go}
  logic [5:0]  ctl0, ctl1;
  logic [63:0] cyc0, ret0;
  logic [3:0]  cyc1, ret1;
  logic [1:0]  st0, st1;

  localparam logic [5:0] c_NONE  = 6'b000000;
  localparam logic [5:0] c_FRZ   = 6'b110010;
  localparam logic [5:0] c_REDIR = 6'b001101;
  localparam logic [5:0] c_STALL = 6'b110100;

  int n_chk = 0;
  int n_err = 0;

  // reference model: bubbles still owed, frozen flag, pending redirect, replay due
  int          m_left[2], n_left[2];
  bit          m_frozen[2], n_frozen[2];
  bit          m_pend[2], n_pend[2];
  bit          m_replay[2], n_replay[2];
  logic [63:0] m_cyc[2], m_ret[2];
  logic [5:0]  e_out[2];

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut0 (
    .clk(clk), .reset(reset),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_exe_memread(exe_memread), .i_exe_rd(exe_rd), .i_exe_redirect(exe_redirect),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready), .i_wb_retire(wb_retire),
    .o_pc_stall(ctl0[5]), .o_ifid_stall(ctl0[4]), .o_ifid_flush(ctl0[3]),
    .o_idexe_flush(ctl0[2]), .o_pipe_freeze(ctl0[1]), .o_redirect_go(ctl0[0]),
    .o_cycle_cnt(cyc0), .o_instret_cnt(ret0), .o_state(st0)
  );

  pipe_hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(id_use_rs1), .i_id_use_rs2(id_use_rs2),
    .i_exe_memread(exe_memread), .i_exe_rd(exe_rd), .i_exe_redirect(exe_redirect),
    .i_mem_req(mem_req), .i_mem_ready(mem_ready), .i_wb_retire(wb_retire),
    .o_pc_stall(ctl1[5]), .o_ifid_stall(ctl1[4]), .o_ifid_flush(ctl1[3]),
    .o_idexe_flush(ctl1[2]), .o_pipe_freeze(ctl1[1]), .o_redirect_go(ctl1[0]),
    .o_cycle_cnt(cyc1), .o_instret_cnt(ret1), .o_state(st1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_state(input int k);
    if (m_replay[k]) return 2'd3;
    if (m_frozen[k]) return 2'd2;
    if (m_left[k] > 0) return 2'd1;
    return 2'd0;
  endfunction

  task automatic eval_model(input int k);
    bit mw, rd, lu;
    int lub;
    lub = (k == 0) ? 1 : 3;
    mw  = mem_req && !mem_ready;
    rd  = exe_redirect;
    lu  = exe_memread && (exe_rd != 0) &&
          ((id_use_rs1 && id_rs1 == exe_rd) || (id_use_rs2 && id_rs2 == exe_rd));
    n_left[k] = m_left[k]; n_frozen[k] = m_frozen[k];
    n_pend[k] = m_pend[k]; n_replay[k] = m_replay[k];
    e_out[k]  = c_NONE;
    if (m_replay[k]) begin
      e_out[k] = c_REDIR; n_replay[k] = 0; n_pend[k] = 0; n_left[k] = 0;
    end else if (m_frozen[k]) begin
      if (mw) begin
        e_out[k] = c_FRZ; n_pend[k] = m_pend[k] | rd;
      end else begin
        n_frozen[k] = 0; n_replay[k] = m_pend[k]; n_pend[k] = 0;
      end
    end else if (mw) begin
      e_out[k] = c_FRZ; n_frozen[k] = 1; n_pend[k] = rd;
    end else if (rd) begin
      e_out[k] = c_REDIR; n_left[k] = 0;
    end else if (m_left[k] > 0) begin
      e_out[k] = c_STALL; n_left[k] = m_left[k] - 1;
    end else if (lu) begin
      e_out[k] = c_STALL; n_left[k] = lub - 1;
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_frozen[k] = 0; m_pend[k] = 0; m_replay[k] = 0;
      m_cyc[k] = '0; m_ret[k] = '0;
    end
  endtask

  // called at a negedge with inputs already applied; returns at the next negedge
  task automatic step();
    #1;
    eval_model(0);
    eval_model(1);
    chk("ctl0", {58'd0, ctl0}, {58'd0, e_out[0]});
    chk("ctl1", {58'd0, ctl1}, {58'd0, e_out[1]});
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_left[k] = n_left[k]; m_frozen[k] = n_frozen[k];
      m_pend[k] = n_pend[k]; m_replay[k] = n_replay[k];
      m_cyc[k]  = m_cyc[k] + 1;
      if (wb_retire && !e_out[k][1]) m_ret[k] = m_ret[k] + 1;
    end
    chk("state0", {62'd0, st0}, {62'd0, exp_state(0)});
    chk("state1", {62'd0, st1}, {62'd0, exp_state(1)});
    chk("cycle0", cyc0, m_cyc[0]);
    chk("instret0", ret0, m_ret[0]);
    chk("cycle1", {60'd0, cyc1}, m_cyc[1] & 64'hF);
    chk("instret1", {60'd0, ret1}, m_ret[1] & 64'hF);
    @(negedge clk);
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic mrd, input logic [4:0] rd, input logic redir,
                        input logic mreq, input logic mrdy, input logic ret);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    exe_memread = mrd; exe_rd = rd; exe_redirect = redir;
    mem_req = mreq; mem_ready = mrdy; wb_retire = ret;
  endtask

  // asserted at a negedge; checks the asynchronous clear before any clock edge
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_ctl0", {58'd0, ctl0}, 64'd0);
    chk("rst_ctl1", {58'd0, ctl1}, 64'd0);
    chk("rst_state0", {62'd0, st0}, 64'd0);
    chk("rst_state1", {62'd0, st1}, 64'd0);
    chk("rst_cycle0", cyc0, 64'd0);
    chk("rst_instret1", {60'd0, ret1}, 64'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    set_in(5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    do_reset();

    // 10 cycles, 6 retire pulses, 2 of them under a two-cycle freeze
    for (int c = 1; c <= 10; c++) begin
      set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, (c == 3 || c == 4 || c == 5), (c == 5),
             (c == 1 || c == 2 || c == 3 || c == 4 || c == 6 || c == 8));
      step();
    end
    chk("cycle_after10", cyc0, 64'd10);
    chk("instret_after10", ret0, 64'd4);

    // load-use via rs1, then bubble in EXE
    set_in(5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_in(5'd5, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    // no hazard: rd = x0, then rs1 not used
    set_in(5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_in(5'd5, 5'd1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    // redirect beats load-use in the same cycle
    set_in(5'd1, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    // memory wait 4 cycles, redirect on the 2nd, then ready
    for (int c = 1; c <= 7; c++) begin
      set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, (c == 2), (c <= 5), (c == 5), 1'b1);
      step();
    end
    // load-use hazard interrupted by a memory wait mid-bubble
    set_in(5'd6, 5'd6, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int c = 1; c <= 6; c++) begin
      set_in(5'd6, 5'd6, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, (c == 1 || c == 2), (c == 2), 1'b0);
      step();
    end

    // 4-bit counters wrap to zero after 16 cycles of retirement
    do_reset();
    set_in(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (16) step();
    chk("cycle_wrap", {60'd0, cyc1}, 64'd0);
    chk("instret_wrap", {60'd0, ret1}, 64'd0);

    // randomized traffic with occasional reset mid-stream
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end
      set_in(5'(5 + $urandom_range(0, 2)), 5'(5 + $urandom_range(0, 2)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'(5 + $urandom_range(0, 2)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
